// File: rtl/booth_pkg.sv
// Shared definitions for the sequential Booth multiplier.
//   booth_state_t : control FSM states (IDLE, CALC, DONE)
//   BOOTH_ADD/SUB : {Q[0], Q_prev} pair codes that select add / subtract of M
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } booth_state_t;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage : booth_pkg

// File: rtl/booth_step.sv
// One radix-2 Booth iteration, purely combinational.
// Ports:
//   a, q, q_prev, m                : current accumulator, multiplier, guard bit, multiplicand
//   a_next, q_next, q_prev_next    : values after add/sub and the 1-bit arithmetic right shift
// All vectors are WIDTH+1 bits so both signed and zero-extended unsigned operands fit.
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] q,
    input  logic           q_prev,
    input  logic [WIDTH:0] m,
    output logic [WIDTH:0] a_next,
    output logic [WIDTH:0] q_next,
    output logic           q_prev_next
);

    logic [WIDTH:0] a_upd_s;

    // Booth recoding: add, subtract or keep the accumulator (wraps modulo 2^(WIDTH+1))
    always_comb begin
        a_upd_s = a;
        case ({q[0], q_prev})
            BOOTH_ADD: a_upd_s = a + m;
            BOOTH_SUB: a_upd_s = a - m;
            default:   a_upd_s = a;
        endcase
    end

    // Arithmetic right shift of the concatenation {A, Q, Q_prev}
    always_comb begin
        a_next      = {a_upd_s[WIDTH], a_upd_s[WIDTH:1]};
        q_next      = {a_upd_s[0], q[WIDTH:1]};
        q_prev_next = q[0];
    end

endmodule : booth_step

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier with valid/ready handshakes on both sides.
// One product at a time, fixed latency of WIDTH+1 edges from acceptance to out_valid.
// Ports:
//   clk, reset          : rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   : operand handshake (in_ready high only in IDLE)
//   num_1, num_2        : multiplicand / multiplier (WIDTH bits)
//   signed_mode         : 1 = two's complement, 0 = unsigned; sampled at acceptance only
//   out_valid/out_ready : result handshake
//   mult_result         : 2*WIDTH-bit product, held after the handshake
//   busy                : high in CALC or DONE
module booth_multiplier_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     num_1,
    input  logic [WIDTH-1:0]     num_2,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   mult_result,
    output logic                 busy
);

    localparam int               CNT_W    = $clog2(WIDTH + 2);
    // Counter value during the final (WIDTH+1-th) iteration
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

    booth_state_t           state_r, state_s;
    logic [WIDTH:0]         a_r, a_s;
    logic [WIDTH:0]         q_r, q_s;
    logic                   q_prev_r, q_prev_s;
    logic [WIDTH:0]         m_r, m_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic [2*WIDTH-1:0]     result_r, result_s;
    logic                   out_valid_r, out_valid_s;

    logic [WIDTH:0]         step_a_s;
    logic [WIDTH:0]         step_q_s;
    logic                   step_q_prev_s;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a           (a_r),
        .q           (q_r),
        .q_prev      (q_prev_r),
        .m           (m_r),
        .a_next      (step_a_s),
        .q_next      (step_q_s),
        .q_prev_next (step_q_prev_s)
    );

    // Next-state and next-datapath logic for the control FSM
    always_comb begin
        state_s     = state_r;
        a_s         = a_r;
        q_s         = q_r;
        q_prev_s    = q_prev_r;
        m_s         = m_r;
        cnt_s       = cnt_r;
        result_s    = result_r;
        out_valid_s = out_valid_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    // Operands widened by one bit so unsigned values stay positive in Booth's signed view
                    m_s      = {signed_mode & num_1[WIDTH-1], num_1};
                    q_s      = {signed_mode & num_2[WIDTH-1], num_2};
                    q_prev_s = 1'b0;
                    a_s      = '0;
                    cnt_s    = '0;
                    state_s  = CALC;
                end else begin
                    state_s  = IDLE;
                end
            end
            CALC: begin
                a_s      = step_a_s;
                q_s      = step_q_s;
                q_prev_s = step_q_prev_s;
                if (cnt_r == LAST_CNT) begin
                    // Product of the widened operands fits in the low 2*WIDTH bits of {A, Q}
                    result_s    = {step_a_s[WIDTH-2:0], step_q_s};
                    out_valid_s = 1'b1;
                    state_s     = DONE;
                end else begin
                    cnt_s       = cnt_r + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_s = 1'b0;
                    state_s     = IDLE;
                end else begin
                    out_valid_s = 1'b1;
                end
            end
            default: begin
                state_s     = IDLE;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            a_r         <= '0;
            q_r         <= '0;
            q_prev_r    <= 1'b0;
            m_r         <= '0;
            cnt_r       <= '0;
            result_r    <= '0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            a_r         <= a_s;
            q_r         <= q_s;
            q_prev_r    <= q_prev_s;
            m_r         <= m_s;
            cnt_r       <= cnt_s;
            result_r    <= result_s;
            out_valid_r <= out_valid_s;
        end
    end

    // Output drive: registered data path, state decode for handshake flags
    always_comb begin
        mult_result = result_r;
        out_valid   = out_valid_r;
        in_ready    = (state_r == IDLE);
        busy        = (state_r == CALC) || (state_r == DONE);
    end

endmodule : booth_multiplier_seq
